// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types and field widths for the tagged branch target buffer
package btb_pkg;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    localparam int PC_W  = 32;
    localparam int TGT_W = 30;
    localparam int CTR_W = 2;

    typedef enum logic {S_IDLE, S_FLUSH} flush_state_t;

    // PC bits that take part in indexing or tagging; everything else is ignored
    function automatic logic [PC_W-1:0] pc_used_mask(input int idx_w, input int tag_w);
        logic [63:0] m;
        m = ((64'd1 << (idx_w + tag_w)) - 64'd1) << 2;
        return m[PC_W-1:0];
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// rtl/btb_sat_ctr.sv - 2-bit saturating direction counter next-value
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic [1:0] i_cur,
    input  logic       i_taken,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_cur;
        case (i_cur)
            SNT:     o_next = i_taken ? WNT : SNT;
            WNT:     o_next = i_taken ? WT  : SNT;
            WT:      o_next = i_taken ? ST  : WNT;
            ST:      o_next = i_taken ? ST  : WT;
            default: o_next = i_cur;
        endcase
    end

endmodule

// File: rtl/btb_tagged.sv
// rtl/btb_tagged.sv - direct-mapped tagged BTB with 2-bit direction counters and a flush sequencer
module btb_tagged
    import btb_pkg::*;
#(
    parameter int         ENTRIES  = 1024,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CTR_INIT = WT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        flush_req,
    output logic        flush_busy
);

    localparam logic [PC_W-1:0]  PC_USED  = pc_used_mask(IDX_W, TAG_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    flush_state_t     r_state;
    flush_state_t     w_state_nxt;
    logic [IDX_W-1:0] r_flush_cnt;
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [TGT_W-1:0] r_target [ENTRIES];
    logic [CTR_W-1:0] r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_busy;
    logic             w_lk_hit;
    logic             w_up_en;
    logic             w_up_hit;
    logic             w_up_alloc;
    logic             w_up_train;
    logic [CTR_W-1:0] w_ctr_nxt;
    logic             w_unused_bits;

    assign w_lk_idx = lookup_pc[IDX_W+1:2];
    assign w_lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_unused_bits = ^{lookup_pc & ~PC_USED, upd_pc & ~PC_USED, upd_target[1:0]};

    assign w_busy   = (r_state == S_FLUSH);
    assign w_lk_hit = r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag) & ~w_busy;

    assign pred_hit    = w_lk_hit;
    assign pred_taken  = w_lk_hit & r_ctr[w_lk_idx][1];
    assign pred_target = w_lk_hit ? {r_target[w_lk_idx], 2'b00} : 32'd0;
    assign flush_busy  = w_busy;

    // A flush request in the same cycle wins over the update, which is dropped
    assign w_up_en    = upd_valid & ~w_busy & ~flush_req;
    assign w_up_hit   = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);
    assign w_up_alloc = w_up_en & ~w_up_hit & upd_taken;
    assign w_up_train = w_up_en & w_up_hit;

    btb_sat_ctr u_sat_ctr (
        .i_cur   (r_ctr[w_up_idx]),
        .i_taken (upd_taken),
        .o_next  (w_ctr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (flush_req) w_state_nxt = S_FLUSH;
            S_FLUSH: if (r_flush_cnt == LAST_IDX) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_valid     <= '0;
        end else if (w_busy) begin
            r_valid[r_flush_cnt] <= 1'b0;
            r_flush_cnt          <= r_flush_cnt + 1'b1;
        end else begin
            if (flush_req) begin
                r_flush_cnt <= '0;
            end
            if (w_up_alloc) begin
                r_valid[w_up_idx] <= 1'b1;
            end
        end
    end

    // Payload arrays carry no reset; valid gates every use of them
    always_ff @(posedge clk) begin
        if (w_up_alloc) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target[31:2];
            r_ctr[w_up_idx]    <= CTR_INIT;
        end else if (w_up_train) begin
            r_ctr[w_up_idx] <= w_ctr_nxt;
            if (upd_taken) begin
                r_target[w_up_idx] <= upd_target[31:2];
            end
        end
    end

endmodule

// File: tb/tb_btb_tagged.sv
// tb/tb_btb_tagged.sv - directed and randomized checks of btb_tagged against a table model
module tb_btb_tagged;

    localparam int ENT = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_busy;

    btb_tagged #(.ENTRIES(ENT), .TAG_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .flush_req   (flush_req),
        .flush_busy  (flush_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid  [ENT];
    int          m_tag    [ENT];
    logic [31:0] m_target [ENT];
    int          m_ctr    [ENT];
    int          m_busy_left = 0;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) & 32'h3ff);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> 12) & 32'hff);
    endfunction

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_lookup(string name);
        int i;
        bit h;
        i = idx_of(lookup_pc);
        h = m_valid[i] && (m_tag[i] == tag_of(lookup_pc)) && (m_busy_left == 0);
        chk({name, ".hit"},    32'(pred_hit),    32'(h));
        chk({name, ".taken"},  32'(pred_taken),  32'(h && m_ctr[i] >= 2));
        chk({name, ".target"}, pred_target,      h ? m_target[i] : 32'd0);
        chk({name, ".busy"},   32'(flush_busy),  32'(m_busy_left > 0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
        m_busy_left = 0;
    endtask

    task automatic model_edge();
        int i;
        bit h;
        if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (flush_req) begin
            for (int k = 0; k < ENT; k++) m_valid[k] = 1'b0;
            m_busy_left = ENT;
        end else if (upd_valid) begin
            i = idx_of(upd_pc);
            h = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
            if (h && upd_taken) begin
                m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_target[i] = upd_target & ~32'd3;
            end else if (h) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end else if (upd_taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(upd_pc);
                m_target[i] = upd_target & ~32'd3;
                m_ctr[i]    = 2;
            end
        end
    endtask

    task automatic cyc(string name, bit do_chk);
        #1;
        if (do_chk) check_lookup(name);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic look(string name, logic [31:0] pc);
        lookup_pc = pc;
        upd_valid = 1'b0;
        flush_req = 1'b0;
        cyc(name, 1'b1);
    endtask

    task automatic upd(logic [31:0] pc, logic [31:0] tgt, logic tk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        cyc("upd", 1'b1);
        upd_valid  = 1'b0;
    endtask

    task automatic do_reset(string name);
        upd_valid = 1'b0;
        flush_req = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_lookup(name);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] hi;
        hi = $urandom;
        return (hi << 20) | (32'($urandom_range(0, 3)) << 12) |
               (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        int busy_cycles;
        logic [31:0] pops [3];
        pops[0] = 32'h0000_3000;
        pops[1] = 32'h0000_1014;
        pops[2] = 32'h0000_1FFC;

        @(posedge clk);
        #1;
        lookup_pc = 32'h0000_1040;
        do_reset("reset");
        look("cold", 32'h0000_1040);

        // allocate; same-cycle lookup must still miss
        lookup_pc = 32'h0000_1040;
        upd(32'h0000_1040, 32'h0000_2000, 1'b1);
        look("alloc_next", 32'h0000_1040);
        chk("alloc_target_const", pred_target, 32'h0000_2000);

        look("alias_miss", 32'h0000_2040);
        upd(32'h0000_2040, 32'h0000_3000, 1'b1);
        look("alias_new", 32'h0000_2040);
        look("alias_old", 32'h0000_1040);

        // counter saturation both ways
        lookup_pc = 32'h0000_6100;
        upd(32'h0000_6100, 32'h0000_7000, 1'b1);
        for (int k = 0; k < 3; k++) upd(32'h0000_6100, 32'h0000_7777, 1'b0);
        look("sat_low", 32'h0000_6100);
        for (int k = 0; k < 4; k++) upd(32'h0000_6100, 32'h0000_7000, 1'b1);
        upd(32'h0000_6100, 32'h0000_7000, 1'b0);
        look("sat_high_nt1", 32'h0000_6100);
        upd(32'h0000_6100, 32'h0000_7000, 1'b0);
        look("sat_high_nt2", 32'h0000_6100);

        // jalr retarget
        upd(32'h0000_6100, 32'h0000_4000, 1'b1);
        look("retarget", 32'h0000_6100);
        upd(32'h0000_6100, 32'h0000_5000, 1'b0);
        look("nt_keeps_target", 32'h0000_6100);
        chk("nt_target_const", pred_target, 32'h0000_4000);

        // full flush with a dropped mid-flush update and an ignored second request
        for (int k = 0; k < 3; k++) upd(pops[k], 32'h0000_8000 + 32'(k * 16), 1'b1);
        for (int k = 0; k < 3; k++) look("pre_flush", pops[k]);
        lookup_pc = pops[0];
        upd_valid = 1'b1;
        upd_pc = 32'h0000_6100;
        upd_target = 32'h0000_9000;
        upd_taken = 1'b1;
        flush_req = 1'b1;
        cyc("flush_req", 1'b1);
        flush_req = 1'b0;
        upd_valid = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < ENT + 4; c++) begin
            lookup_pc = pops[c % 3];
            upd_valid = (c == 50);
            upd_pc = 32'h0000_5080;
            upd_target = 32'h0000_A000;
            upd_taken = 1'b1;
            flush_req = (c == 200);
            #1;
            if (flush_busy === 1'b1) busy_cycles++;
            cyc("flushing", 1'b1);
        end
        upd_valid = 1'b0;
        flush_req = 1'b0;
        chk("busy_cycles", 32'(busy_cycles), 32'(ENT));
        for (int k = 0; k < 3; k++) look("post_flush", pops[k]);
        look("midflush_upd", 32'h0000_5080);
        look("flush_drop_upd", 32'h0000_6100);

        // reset aborts a flush in progress
        for (int k = 0; k < 3; k++) upd(pops[k], 32'h0000_B000, 1'b1);
        look("repop", pops[2]);
        flush_req = 1'b1;
        cyc("flush2_req", 1'b1);
        flush_req = 1'b0;
        for (int c = 0; c < 100; c++) begin
            lookup_pc = pops[c % 3];
            cyc("flush2", 1'b1);
        end
        lookup_pc = pops[1];
        do_reset("rst_midflush");
        for (int k = 0; k < 3; k++) look("after_abort", pops[k]);

        // randomized traffic over a small aliasing address pool
        for (int c = 0; c < 3000; c++) begin
            lookup_pc  = rand_pc();
            upd_valid  = 1'($urandom_range(0, 1));
            upd_pc     = ($urandom_range(0, 3) == 0) ? lookup_pc : rand_pc();
            upd_target = $urandom;
            upd_taken  = ($urandom_range(0, 2) != 0);
            flush_req  = ($urandom_range(0, 799) == 0);
            cyc("rand", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
